// File: rtl/fetch_instr_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_instr_queue.
// master drives words and decode control; slave (the queue) presents the head entry.
interface fetch_instr_queue_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            WordValidF;
    logic [31:0]     WordF;
    logic [XLEN-1:0] PCF;
    logic            WordReadyF;
    logic            InstrLenF;
    logic            StallD;
    logic            FlushD;
    logic            InstrValidD;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic            CompressedD;
    logic            MisalignedD;
    logic [CW-1:0]   CountD;

    modport master (
        output WordValidF, WordF, PCF, StallD, FlushD,
        input  WordReadyF, InstrLenF, InstrValidD, InstrD, PCD,
               CompressedD, MisalignedD, CountD
    );

    modport slave (
        input  WordValidF, WordF, PCF, StallD, FlushD,
        output WordReadyF, InstrLenF, InstrValidD, InstrD, PCD,
               CompressedD, MisalignedD, CountD
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// Circular FIFO between fetch buffer and decode: classifies each word as 16/32-bit,
// stores it with its PC, and presents the head combinationally. The interface must use the same XLEN/DEPTH.
module fetch_instr_queue #(
    parameter int          XLEN  = 64,
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    fetch_instr_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic            compressed;
        logic            misaligned;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          empty, full, push, pop;
    entry_t        wr_entry, head;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // Ready is a function of stored state only, so decode stalls never reach fetch combinationally.
    assign q.WordReadyF = ~full;
    assign q.InstrLenF  = (q.WordF[1:0] == 2'b11);

    assign push = q.WordValidF & ~full & ~q.FlushD;
    assign pop  = ~empty & ~q.StallD & ~q.FlushD;

    always_comb begin
        wr_entry            = '0;
        wr_entry.instr      = q.InstrLenF ? q.WordF : {16'h0, q.WordF[15:0]};
        wr_entry.pc         = q.PCF;
        wr_entry.compressed = ~q.InstrLenF;
        wr_entry.misaligned = q.PCF[0];
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (q.FlushD) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wr_entry;
    end

    assign head = mem_q[rptr_q[AW-1:0]];

    assign q.InstrValidD = ~empty;
    assign q.InstrD      = empty ? NOP : head.instr;
    assign q.PCD         = empty ? '0 : head.pc;
    assign q.CompressedD = ~empty & head.compressed;
    assign q.MisalignedD = ~empty & head.misaligned;
    assign q.CountD      = wptr_q - rptr_q;
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Randomized + directed bench for fetch_instr_queue against a queue-based reference model.
module tb_fetch_instr_queue;
    localparam int          XLEN  = 64;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        comp;
        logic        mis;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_instr_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of instructions; RISC-V length rule decides compression.
    always @(posedge clk) begin
        if (reset) begin
            if (bus.FlushD) mq.delete();
            else begin
                bit do_pop, do_push;
                ent_t e;
                do_pop  = (mq.size() > 0) && !bus.StallD;
                do_push = bus.WordValidF && (mq.size() < DEPTH);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.comp  = (bus.WordF[1:0] != 2'b11);
                    e.instr = e.comp ? {16'h0, bus.WordF[15:0]} : bus.WordF;
                    e.pc    = bus.PCF;
                    e.mis   = bus.PCF[0];
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge reset) mq.delete();

    // Single compare process: outputs are checked mid-cycle, every cycle.
    always @(negedge clk) begin
        chk("ready", 64'(bus.WordReadyF), 64'(mq.size() < DEPTH));
        chk("len",   64'(bus.InstrLenF),  64'(bus.WordF[1:0] == 2'b11));
        chk("valid", 64'(bus.InstrValidD), 64'(mq.size() > 0));
        chk("count", 64'(bus.CountD),      64'(mq.size()));
        if (mq.size() > 0) begin
            chk("instr", 64'(bus.InstrD),      64'(mq[0].instr));
            chk("pc",    bus.PCD,              mq[0].pc);
            chk("comp",  64'(bus.CompressedD), 64'(mq[0].comp));
            chk("mis",   64'(bus.MisalignedD), 64'(mq[0].mis));
        end else begin
            chk("instr_e", 64'(bus.InstrD), 64'(NOP));
            chk("pc_e",    bus.PCD, 64'h0);
            chk("comp_e",  64'({bus.CompressedD, bus.MisalignedD}), 64'h0);
        end
    end

    task automatic set_in(input logic v, input logic [31:0] w, input logic [63:0] pc,
                          input logic st, input logic fl);
        bus.WordValidF = v;
        bus.WordF      = w;
        bus.PCF        = pc;
        bus.StallD     = st;
        bus.FlushD     = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] seen[$];
        int k, cyc;
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Reset then idle
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 64'(bus.InstrValidD), 64'h0);
        chk("rst_instr", 64'(bus.InstrD), 64'h13);
        chk("rst_count", 64'(bus.CountD), 64'h0);
        chk("rst_ready", 64'(bus.WordReadyF), 64'h1);
        reset = 1'b1;
        tick();

        // Mixed lengths
        set_in(1'b1, 32'h00A00093, 64'h1000, 1'b0, 1'b0);
        #1 chk("len32", 64'(bus.InstrLenF), 64'h1);
        tick();
        chk("mix1_instr", 64'(bus.InstrD), 64'h00A00093);
        chk("mix1_pc", bus.PCD, 64'h1000);
        chk("mix1_comp", 64'(bus.CompressedD), 64'h0);
        set_in(1'b1, 32'hFFFF4505, 64'h1004, 1'b0, 1'b0);
        #1 chk("len16", 64'(bus.InstrLenF), 64'h0);
        tick();
        chk("mix2_instr", 64'(bus.InstrD), 64'h00004505);
        chk("mix2_pc", bus.PCD, 64'h1004);
        chk("mix2_comp", 64'(bus.CompressedD), 64'h1);
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        tick();
        chk("mix_drain", 64'(bus.CountD), 64'h0);

        // Fill and backpressure
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h00000013 + 32'(i << 7), 64'h100 + 64'(4 * i), 1'b1, 1'b0);
            tick();
        end
        chk("fill_count", 64'(bus.CountD), 64'h4);
        chk("fill_ready", 64'(bus.WordReadyF), 64'h0);
        chk("fill_head", bus.PCD, 64'h100);
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        #1 chk("no_comb_ready", 64'(bus.WordReadyF), 64'h0);
        tick();
        chk("bp_count", 64'(bus.CountD), 64'h3);
        chk("bp_ready", 64'(bus.WordReadyF), 64'h1);

        // Flush with a simultaneous push
        set_in(1'b1, 32'h12345677, 64'h500, 1'b1, 1'b1);
        tick();
        chk("flush_count", 64'(bus.CountD), 64'h0);
        chk("flush_valid", 64'(bus.InstrValidD), 64'h0);
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        tick();
        chk("flush_absent", 64'(bus.InstrValidD), 64'h0);

        // Wrap-around stream with StallD toggling every 3 cycles
        k = 0;
        cyc = 0;
        while ((k < 20 || bus.InstrValidD) && cyc < 300) begin
            logic st;
            st = ((cyc / 3) % 2) == 1;
            set_in(k < 20, $urandom, 64'h2000 + 64'(4 * k), st, 1'b0);
            #1;
            if (bus.InstrValidD && !st) seen.push_back(bus.PCD);
            if (k < 20 && bus.WordReadyF) k++;
            tick();
            cyc++;
        end
        if (cyc >= 300) chk("wrap_timeout", 64'(cyc), 64'h0);
        chk("wrap_len", 64'(seen.size()), 64'd20);
        foreach (seen[i]) chk("wrap_order", seen[i], 64'h2000 + 64'(4 * i));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom), $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 15) == 0));
            tick();
        end

        // Misaligned PC, then asynchronous reset mid-cycle
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 32'h00A00093, 64'h3001, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("mis_head", 64'(bus.MisalignedD), 64'h1);
        chk("mis_count", 64'(bus.CountD), 64'h1);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.InstrValidD), 64'h0);
        chk("arst_count", 64'(bus.CountD), 64'h0);
        chk("arst_ready", 64'(bus.WordReadyF), 64'h1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
